md_unit: RTL and testbench

//  Multiply/divide unit with HI/LO registers for the MIPS CPU, in the execute stage.

---
 rtl/md_unit_pkg.sv | 67 ++++++
 rtl/md_unit.sv | 103 ++++++++++
 tb/tb_md_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings, FSM states
// and the combinational HI/LO result function.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic        wr;   // 0: HI/LO keep their values at commit (divide by zero)
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic md_res_t md_compute(input md_op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    md_res_t     r;
    logic [63:0] p;
    logic [31:0] d;
    r = '{wr: 1'b1, hi: 32'd0, lo: 32'd0};
    p = 64'd0;
    // A zero divisor is replaced so the divider never sees it; wr masks the result.
    d = (b == 32'd0) ? 32'd1 : b;
    case (op)
      MD_MULT: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MD_DIV: begin
        r.wr = (b != 32'd0);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000;
          r.hi = 32'd0;
        end else begin
          r.lo = $signed(a) / $signed(d);
          r.hi = $signed(a) % $signed(d);
        end
      end
      MD_DIVU: begin
        r.wr = (b != 32'd0);
        r.lo = a / d;
        r.hi = a % d;
      end
      default: r.wr = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers. The result is computed
// at the start edge and held pending until a fixed-latency counter expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output md_state_e   state_dbg
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Handshake: start is a one-cycle request, accepted only when state is IDLE;
  // a start seen while RUN is dropped. done pulses for the cycle after commit.

  md_state_e     state, state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cyc_load;
  md_res_t       pend;
  md_op_e        op;
  logic          launch, commit, wr_hi, wr_lo;

  assign op        = md_op_e'(md_op);
  assign state_dbg = state;
  assign cyc_load  = (op == MD_MULT || op == MD_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    commit     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              launch     = 1'b1;
              state_next = ST_RUN;
            end
            MD_MTHI: wr_hi = 1'b1;
            MD_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt == CW'(1)) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
      pend <= '0;
    end else begin
      done <= commit;
      if (launch) begin
        pend <= md_compute(op, rs_val, rt_val);
        cnt  <= cyc_load;
        busy <= 1'b1;
      end else if (state == ST_RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        busy <= 1'b0;
        if (pend.wr) begin
          hi <= pend.hi;
          lo <= pend.lo;
        end
      end
      if (wr_hi) hi <= rs_val;
      if (wr_lo) lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, HI/LO results, reset abort, mthi/mtlo,
// divide by zero, start-while-busy and back-to-back issue.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  md_state_e   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: one-cycle start pulse; returns at the negedge after the start edge
  task automatic do_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    md_op  = 3'd7;
  endtask

  // counts busy cycles from the current negedge; ends on the negedge where done is seen
  task automatic wait_commit(input int n_exp, input string tag);
    int n;
    logic [63:0] e;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(n_exp));
    check({tag, "_done"}, 64'(done), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
    check({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    int pulses;
    reset  = 1'b0;
    start  = 1'b0;
    md_op  = 3'd7;
    rs_val = 32'd0;
    rt_val = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b1;

    // 1: reset in the middle of a MULT aborts it
    do_start(3'(MD_MTHI), 32'hAAAA_5555, 32'd0);
    do_start(3'(MD_MTLO), 32'h5555_AAAA, 32'd0);
    check("mt_pre", {hi, lo}, 64'hAAAA_5555_5555_AAAA);
    do_start(3'(MD_MULT), 32'd3, 32'd4);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check("abort_no_commit", 64'(pulses), 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);

    // 2: signed multiply, old HI/LO visible while busy
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    do_start(3'(MD_MULT), 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_old_hilo", {hi, lo}, 64'd0);
    wait_commit(5, "mult");
    @(negedge clk);
    check("mult_done_pulse", 64'(done), 64'd0);

    // 3: unsigned multiply
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    do_start(3'(MD_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_commit(5, "multu");

    // 4: signed/unsigned divide and the signed overflow case
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    do_start(3'(MD_DIV), 32'hFFFF_FFF9, 32'd2);
    wait_commit(10, "div");
    exp_q.push_back(64'h0000_0001_7FFF_FFFC);
    do_start(3'(MD_DIVU), 32'hFFFF_FFF9, 32'd2);
    wait_commit(10, "divu");
    exp_q.push_back(64'h0000_0000_8000_0000);
    do_start(3'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF);
    wait_commit(10, "div_ovf");

    // 5: mthi/mtlo, then divide by zero leaves HI/LO alone
    do_start(3'(MD_MTHI), 32'h1234_5678, 32'd0);
    check("mthi_hilo", {hi, lo}, 64'h1234_5678_8000_0000);
    check("mthi_busy", 64'(busy), 64'd0);
    do_start(3'(MD_MTLO), 32'h0BAD_F00D, 32'd0);
    check("mtlo_hilo", {hi, lo}, 64'h1234_5678_0BAD_F00D);
    exp_q.push_back(64'h1234_5678_0BAD_F00D);
    do_start(3'(MD_DIV), 32'd99, 32'd0);
    wait_commit(10, "div0");

    // 6: start while busy is dropped; start right after commit is accepted
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    start  = 1'b1;
    md_op  = 3'(MD_MULT);
    rs_val = 32'd7;
    rt_val = 32'hFFFF_FFFD;
    @(negedge clk);
    md_op  = 3'(MD_DIV);
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(negedge clk);
    start  = 1'b0;
    wait_commit(4, "ignore");
    exp_q.push_back(64'h0000_0001_0000_0000);
    start  = 1'b1;
    md_op  = 3'(MD_MULTU);
    rs_val = 32'h0001_0000;
    rt_val = 32'h0001_0000;
    @(negedge clk);
    start  = 1'b0;
    check("b2b_done_low", 64'(done), 64'd0);
    check("b2b_state", 64'(state_dbg), 64'(ST_RUN));
    wait_commit(5, "b2b");

    // op 6 does nothing
    do_start(3'(MD_NOP6), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("nop_busy", 64'(busy), 64'd0);
    check("nop_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    check("nop_state", 64'(state_dbg), 64'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
